// File: rtl/iso7816_rx_buffer.sv
// rtl/iso7816_rx_buffer.sv - ISO7816 receiver character buffer: flag handshake, tagged FWFT FIFO, drop/overrun counters
module iso7816_rx_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [7:0]            rxData,
    input  logic                  rxDataReady,
    input  logic                  rxFrameError,
    input  logic                  rxOverrunError,
    output logic                  rxAckFlags,
    input  logic                  flush,
    input  logic                  pop,
    output logic [7:0]            headData,
    output logic                  headError,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [CNT_WIDTH-1:0]  dropCount,
    output logic [CNT_WIDTH-1:0]  overrunCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        WAIT_EVT = 2'd0,
        ACK_WAIT = 2'd1
    } state_t;

    state_t         state;
    logic [8:0]     mem [DEPTH];
    logic [PW-1:0]  wPtr;
    logic [PW-1:0]  rPtr;
    logic           ovrPrev;
    logic           capture;
    logic           popEn;
    logic           pushEn;
    logic           dropInc;
    logic           ovrRise;

    assign empty   = (wPtr == rPtr);
    assign full    = (wPtr[DEPTH_LOG2] != rPtr[DEPTH_LOG2]) &&
                     (wPtr[DEPTH_LOG2-1:0] == rPtr[DEPTH_LOG2-1:0]);
    assign level   = wPtr - rPtr;
    assign {headError, headData} = mem[rPtr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign capture = (state == WAIT_EVT) && (rxDataReady || rxFrameError);
    assign popEn   = pop && !empty;
    assign pushEn  = capture && !flush && (!full || popEn);
    assign dropInc = capture && !flush && full && !popEn;
    assign ovrRise = rxOverrunError && !ovrPrev;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= WAIT_EVT;
            rxAckFlags <= 1'b0;
        end else begin
            case (state)
                WAIT_EVT: begin
                    if (capture) begin
                        rxAckFlags <= 1'b1;
                        state      <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (!rxDataReady && !rxFrameError) begin
                        rxAckFlags <= 1'b0;
                        state      <= WAIT_EVT;
                    end
                end
                default: begin
                    rxAckFlags <= 1'b0;
                    state      <= WAIT_EVT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wPtr[DEPTH_LOG2-1:0]] <= {rxFrameError, rxData};
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wPtr      <= '0;
            rPtr      <= '0;
            dropCount <= '0;
        end else if (flush) begin
            wPtr      <= '0;
            rPtr      <= '0;
            dropCount <= '0;
        end else begin
            if (pushEn) begin
                wPtr <= wPtr + PW'(1);
            end
            if (popEn) begin
                rPtr <= rPtr + PW'(1);
            end
            if (dropInc && (dropCount != {CNT_WIDTH{1'b1}})) begin
                dropCount <= dropCount + CNT_WIDTH'(1);
            end
        end
    end

    // Edge detector runs through flush so a level held across flush is not recounted.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ovrPrev      <= 1'b0;
            overrunCount <= '0;
        end else begin
            ovrPrev <= rxOverrunError;
            if (flush) begin
                overrunCount <= '0;
            end else if (ovrRise && (overrunCount != {CNT_WIDTH{1'b1}})) begin
                overrunCount <= overrunCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_iso7816_rx_buffer.sv
// tb/tb_iso7816_rx_buffer.sv - scoreboard bench for iso7816_rx_buffer
module tb_iso7816_rx_buffer;

    logic        clk;
    logic        nReset;
    logic [7:0]  rxData;
    logic        rxDataReady;
    logic        rxFrameError;
    logic        rxOverrunError;
    logic        rxAckFlags;
    logic        flush;
    logic        pop;
    logic [7:0]  headData;
    logic        headError;
    logic        empty;
    logic        full;
    logic [3:0]  level;
    logic [7:0]  dropCount;
    logic [7:0]  overrunCount;

    int checks;
    int failures;
    logic [8:0] sbQ[$];
    logic [8:0] expEntry;

    iso7816_rx_buffer #(.DEPTH_LOG2(3), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .nReset         (nReset),
        .rxData         (rxData),
        .rxDataReady    (rxDataReady),
        .rxFrameError   (rxFrameError),
        .rxOverrunError (rxOverrunError),
        .rxAckFlags     (rxAckFlags),
        .flush          (flush),
        .pop            (pop),
        .headData       (headData),
        .headError      (headError),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .dropCount      (dropCount),
        .overrunCount   (overrunCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever a pop is presented on a non-empty FIFO, the head must match the oldest expected entry.
    always @(negedge clk) begin
        if (nReset && pop && !empty) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=0x%0h expected=none at %0t", {headError, headData}, $time);
            end else begin
                expEntry = sbQ.pop_front();
                check("sb_head", {23'd0, headError, headData}, {23'd0, expEntry});
            end
        end
    end

    task automatic sendByte(input logic [7:0] d, input logic fe, input logic rdy, input logic stored);
        rxData       = d;
        rxDataReady  = rdy;
        rxFrameError = fe;
        @(posedge clk); #1;
        if (stored) sbQ.push_back({fe, d});
        check("ack_set", {31'd0, rxAckFlags}, 32'd1);
        rxDataReady  = 1'b0;
        rxFrameError = 1'b0;
        @(posedge clk); #1;
        check("ack_clr", {31'd0, rxAckFlags}, 32'd0);
    endtask

    task automatic popOne();
        pop = 1'b1;
        @(posedge clk); #1;
        pop = 1'b0;
    endtask

    task automatic checkFlags(input string tag, input logic e, input logic f, input int lvl, input int drp);
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, e});
        check({tag, "_full"},  {31'd0, full},  {31'd0, f});
        check({tag, "_level"}, {28'd0, level}, lvl);
        check({tag, "_drop"},  {24'd0, dropCount}, drp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        nReset = 1'b0;
        rxData = 8'h00;
        rxDataReady = 1'b0;
        rxFrameError = 1'b0;
        rxOverrunError = 1'b0;
        flush = 1'b0;
        pop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkFlags("reset", 1'b1, 1'b0, 0, 0);
        check("reset_ack", {31'd0, rxAckFlags}, 32'd0);
        check("reset_ovr", {24'd0, overrunCount}, 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk); #1;

        // Single byte
        rxData = 8'h3B;
        rxDataReady = 1'b1;
        @(posedge clk); #1;
        sbQ.push_back({1'b0, 8'h3B});
        check("single_ack", {31'd0, rxAckFlags}, 32'd1);
        check("single_data", {24'd0, headData}, 32'h3B);
        check("single_err", {31'd0, headError}, 32'd0);
        checkFlags("single", 1'b0, 1'b0, 1, 0);
        rxDataReady = 1'b0;
        @(posedge clk); #1;
        check("single_ackclr", {31'd0, rxAckFlags}, 32'd0);
        popOne();
        checkFlags("single_pop", 1'b1, 1'b0, 0, 0);

        // Frame error alone, then both flags together
        sendByte(8'hA5, 1'b1, 1'b0, 1'b1);
        check("ferr_data", {24'd0, headData}, 32'hA5);
        check("ferr_err", {31'd0, headError}, 32'd1);
        popOne();
        sendByte(8'h5A, 1'b1, 1'b1, 1'b1);
        check("both_err", {31'd0, headError}, 32'd1);
        popOne();
        sendByte(8'hC3, 1'b0, 1'b1, 1'b1);
        popOne();

        // Full FIFO: 9th byte acknowledged but dropped
        for (int i = 0; i < 9; i++) sendByte(8'(i), 1'b0, 1'b1, i < 8);
        checkFlags("full", 1'b0, 1'b1, 8, 1);
        // Pop while empty must be ignored after draining
        for (int i = 0; i < 8; i++) popOne();
        checkFlags("drained", 1'b1, 1'b0, 0, 1);
        popOne();
        checkFlags("pop_empty", 1'b1, 1'b0, 0, 1);

        // Build 3 entries with dropCount=2, then flush
        for (int i = 0; i < 9; i++) sendByte(8'h10 + 8'(i), 1'b0, 1'b1, i < 8);
        for (int i = 0; i < 5; i++) popOne();
        checkFlags("preflush", 1'b0, 1'b0, 3, 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sbQ.delete();
        checkFlags("flush", 1'b1, 1'b0, 0, 0);

        // Event during flush: acknowledged, not stored
        rxData = 8'hEE;
        rxDataReady = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        rxDataReady = 1'b0;
        check("flushevt_ack", {31'd0, rxAckFlags}, 32'd1);
        checkFlags("flushevt", 1'b1, 1'b0, 0, 0);
        @(posedge clk); #1;
        check("flushevt_ackclr", {31'd0, rxAckFlags}, 32'd0);

        // Full with same-cycle pop on the 9th event
        for (int i = 0; i < 8; i++) sendByte(8'(i), 1'b0, 1'b1, 1'b1);
        rxData = 8'h08;
        rxDataReady = 1'b1;
        pop = 1'b1;
        @(posedge clk); #1;
        pop = 1'b0;
        sbQ.push_back({1'b0, 8'h08});
        checkFlags("fullpop", 1'b0, 1'b1, 8, 0);
        check("fullpop_head", {24'd0, headData}, 32'h01);
        rxDataReady = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) popOne();
        checkFlags("fullpop_drain", 1'b1, 1'b0, 0, 0);

        // Overrun counting and saturation
        for (int i = 0; i < 300; i++) begin
            rxOverrunError = 1'b1;
            @(posedge clk); #1;
            rxOverrunError = 1'b0;
            @(posedge clk); #1;
        end
        check("ovr_sat", {24'd0, overrunCount}, 32'd255);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("ovr_flush", {24'd0, overrunCount}, 32'd0);
        rxOverrunError = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rxOverrunError = 1'b0;
        @(posedge clk); #1;
        check("ovr_hold", {24'd0, overrunCount}, 32'd1);

        // Reset during ACK_WAIT, then recapture
        rxData = 8'h77;
        rxDataReady = 1'b1;
        @(posedge clk); #1;
        check("mid_ack", {31'd0, rxAckFlags}, 32'd1);
        check("mid_level", {28'd0, level}, 32'd1);
        nReset = 1'b0;
        #1;
        sbQ.delete();
        check("rst_ack", {31'd0, rxAckFlags}, 32'd0);
        checkFlags("rst", 1'b1, 1'b0, 0, 0);
        check("rst_ovr", {24'd0, overrunCount}, 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk); #1;
        sbQ.push_back({1'b0, 8'h77});
        check("recap_ack", {31'd0, rxAckFlags}, 32'd1);
        check("recap_data", {24'd0, headData}, 32'h77);
        checkFlags("recap", 1'b0, 1'b0, 1, 0);
        rxDataReady = 1'b0;
        @(posedge clk); #1;
        popOne();
        check("sb_leftover", sbQ.size(), 32'd0);
        checkFlags("end", 1'b1, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
